mem_dp_pipe: RTL and testbench
==============================

Name: mem_dp_pipe

Overview:
Parametrised simple-dual-port RAM, one write port and one read port, successor to the 8x6 storage block used under the FIFOs. Adds:
- selectable read/write collision policy
- optional output pipeline stage
- out-of-range address checking
- per-entry written flags
- saturating error counter with clear

Sits under the FIFO/buffer blocks as their storage element.

Parameters:
DATA_WIDTH, 6, word width in bits
ADDR_WIDTH, 3, address width in bits
RAM_DEPTH, 8, number of entries; must satisfy 1 <= RAM_DEPTH <= 2**ADDR_WIDTH
COLLISION_MODE, 0, policy when read and write target the same address: 0=error, 1=write-first, 2=read-first
READ_LATENCY, 1, cycles from read request to data_out/valid_out; legal values 1 or 2
ERR_CNT_WIDTH, 4, width of the saturating error counter

Ports:
clk  in  1  clock; all state updates on rising edge
RESET_L  in  1  asynchronous active-low reset
write  in  1  write request
address_write  in  ADDR_WIDTH  write address
data  in  DATA_WIDTH  write data
read  in  1  read request
address_read  in  ADDR_WIDTH  read address
err_clr  in  1  synchronous clear of err_count
data_out  out  DATA_WIDTH  read data, valid when valid_out=1, else 0
valid_out  out  1  read data valid
err  out  1  collision error pulse, aligned with the read it affected
err_oor  out  1  out-of-range address pulse, aligned with read-result timing
uninit  out  1  read returned an entry never written since reset
err_count  out  ERR_CNT_WIDTH  saturating count of err and err_oor events

Behaviour:
Reset (RESET_L=0, asynchronous, immediate):
- all entries and written flags = 0
- all pipeline stages cleared
- data_out=0, valid_out=0, err=0, err_oor=0, uninit=0, err_count=0
- reset mid-operation discards in-flight reads; no valid_out appears after release

Write accepted when write=1 and address_write < RAM_DEPTH, subject to collision policy. It sets mem[address_write]=data and written[address_write]=1. It is visible to reads in the following cycle.

Read accepted when read=1 and address_read < RAM_DEPTH. Stage-1 result is:
- data = mem[address_read]
- valid = 1
- uninit = ~written[address_read]

Collision (read=1, write=1, address_read==address_write, both in range):
- mode 0: write dropped, read dropped; stage-1 valid=0, data=0, err=1 (matches the previous-generation behaviour)
- mode 1: write committed; read returns the new data; err=0; uninit=0
- mode 2: write committed; read returns the old content; err=0; uninit reflects the flag before the write

Out of range (either request address >= RAM_DEPTH):
- that request is dropped and err_oor=1
- if the read was the dropped one: valid=0, data=0
- a legal request on the other port still proceeds
- no collision check is made when either address is out of range

Idle cycle (no read): stage-1 valid=0, data=0, uninit=0. err and err_oor are 0 unless a write-side error occurred that cycle.

Latency:
- READ_LATENCY=1: stage-1 registers drive the outputs directly, so a read at edge N gives outputs after edge N
- READ_LATENCY=2: one extra register stage, so outputs appear after edge N+1
- err, err_oor and uninit always travel with the same pipeline as the read result
- back-to-back reads give one result per cycle; no stalls, no backpressure

err_count:
- increments by 1 per cycle in which the stage-1 err or err_oor is 1 (one count per cycle even if both are set)
- saturates at all-ones
- err_clr=1 sets it to 0 on the next edge; clear has priority over an increment in the same cycle

Parameter errors: illegal parameter values are rejected at elaboration via a generate-time check.

Decomposition:
Shared package mem_pkg holds:
- collision-mode constants COLL_ERR=0, COLL_WRITE_FIRST=1, COLL_READ_FIRST=2
- a read-result struct/bundle {data, valid, err, err_oor, uninit}

One natural sub-module, mem_rd_pipe: a parametrised delay line for the read-result bundle, depth READ_LATENCY-1, clearing asynchronously on reset. The storage array, collision logic and err_count stay in mem_dp_pipe.

Test Plan:
- Reset, write 0x2A@3, read@3 next cycle, READ_LATENCY=1 -> after next edge data_out=0x2A, valid_out=1, uninit=0, err=0.
- Mode 0, write 0x15@5 and read@5 same cycle after mem[5]=0x07 -> valid_out=0, data_out=0, err=1, mem[5] stays 0x07, err_count=1.
- Modes 1/2, mem[2]=0x01, write 0x3F@2 with read@2 -> mode 1 data_out=0x3F; mode 2 data_out=0x01; both give mem[2]=0x3F and err=0.
- RAM_DEPTH=6, ADDR_WIDTH=3: read@7 with write 0x11@1 -> err_oor=1, valid_out=0, mem[1]=0x11; 20 such cycles with ERR_CNT_WIDTH=4 -> err_count holds 15; err_clr -> 0.
- READ_LATENCY=2, reads @0,@1,@2 back-to-back (unwritten) -> three consecutive valid_out=1 starting two edges after the first request, each with uninit=1, data 0.
- Read issued, RESET_L pulsed low mid-cycle before the result emerges -> outputs 0 immediately, no valid_out after release, all entries read back 0 with uninit=1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port storage block: collision-mode
// encodings and the read-result flag bundle carried down the read pipeline.
package mem_pkg;

  localparam int COLL_ERR         = 0;
  localparam int COLL_WRITE_FIRST = 1;
  localparam int COLL_READ_FIRST  = 2;

  // Status that travels alongside the read data; the data word itself is
  // parameter-sized and rides next to this bundle.
  typedef struct packed {
    logic valid;
    logic err;
    logic err_oor;
    logic uninit;
  } rd_flags_t;

  localparam rd_flags_t RD_FLAGS_IDLE = '{valid: 1'b0, err: 1'b0, err_oor: 1'b0, uninit: 1'b0};

endpackage

// File: rtl/mem_rd_pipe.sv
// Delay line for the read result (data word plus status flags).
// Every stage clears asynchronously so no stale result survives a reset.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  RESET_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  rd_flags_t             flags_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output rd_flags_t             flags_out
);

  logic [DATA_WIDTH-1:0] data_r  [DEPTH];
  rd_flags_t             flags_r [DEPTH];

  // Shift the read result one stage per clock.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i]  <= '0;
        flags_r[i] <= RD_FLAGS_IDLE;
      end
    end else begin
      data_r[0]  <= data_in;
      flags_r[0] <= flags_in;
      for (int i = 1; i < DEPTH; i++) begin
        data_r[i]  <= data_r[i-1];
        flags_r[i] <= flags_r[i-1];
      end
    end
  end

  assign data_out  = data_r[DEPTH-1];
  assign flags_out = flags_r[DEPTH-1];

endmodule

// File: rtl/mem_dp_pipe.sv
// Simple dual-port RAM (one write port, one read port) with selectable
// same-address collision policy, optional extra output stage, out-of-range
// detection, per-entry written flags and a saturating error counter.
module mem_dp_pipe
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 6,
  parameter int ADDR_WIDTH     = 3,
  parameter int RAM_DEPTH      = 8,
  parameter int COLLISION_MODE = 0,
  parameter int READ_LATENCY   = 1,
  parameter int ERR_CNT_WIDTH  = 4
) (
  input  logic                     clk,
  input  logic                     RESET_L,
  input  logic                     write,
  input  logic [ADDR_WIDTH-1:0]    address_write,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     read,
  input  logic [ADDR_WIDTH-1:0]    address_read,
  input  logic                     err_clr,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     valid_out,
  output logic                     err,
  output logic                     err_oor,
  output logic                     uninit,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  // Reject illegal configurations at elaboration.
  if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 || RAM_DEPTH < 1 ||
      RAM_DEPTH > (1 << ADDR_WIDTH) ||
      (COLLISION_MODE != COLL_ERR && COLLISION_MODE != COLL_WRITE_FIRST &&
       COLLISION_MODE != COLL_READ_FIRST) ||
      READ_LATENCY < 1 || READ_LATENCY > 2 || ERR_CNT_WIDTH < 1) begin : g_param_err
    $error("mem_dp_pipe: illegal parameter combination");
  end

  // One extra bit so a depth of exactly 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0]    mem_r [RAM_DEPTH];
  logic [RAM_DEPTH-1:0]     written_r;
  logic [DATA_WIDTH-1:0]    s1_data_r;
  rd_flags_t                s1_flags_r;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_r;

  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  collide_s;
  logic                  drop_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [DATA_WIDTH-1:0] s1_data_s;
  rd_flags_t             s1_flags_s;
  logic [DATA_WIDTH-1:0] pipe_data_s;
  rd_flags_t             pipe_flags_s;

  // Decode requests, apply range checks and the collision policy, and form
  // the stage-1 read result.
  always_comb begin
    wr_in_range_s = ({1'b0, address_write} < DEPTH_L);
    rd_in_range_s = ({1'b0, address_read} < DEPTH_L);
    // Collision only counts when both addresses are legal.
    collide_s = write & read & wr_in_range_s & rd_in_range_s &
                (address_write == address_read);
    drop_s    = collide_s && (COLLISION_MODE == COLL_ERR);
    wr_en_s   = write & wr_in_range_s & ~drop_s;
    rd_en_s   = read & rd_in_range_s & ~drop_s;

    s1_data_s  = '0;
    s1_flags_s = RD_FLAGS_IDLE;
    if (rd_en_s) begin
      s1_flags_s.valid = 1'b1;
      if (collide_s && (COLLISION_MODE == COLL_WRITE_FIRST)) begin
        // Forward the incoming word; it is written this cycle.
        s1_data_s         = data;
        s1_flags_s.uninit = 1'b0;
      end else begin
        // Read-first falls out naturally: the array still holds old content.
        s1_data_s         = mem_r[address_read];
        s1_flags_s.uninit = ~written_r[address_read];
      end
    end else begin
      s1_data_s         = '0;
      s1_flags_s.valid  = 1'b0;
      s1_flags_s.uninit = 1'b0;
    end
    s1_flags_s.err     = drop_s;
    s1_flags_s.err_oor = (write & ~wr_in_range_s) | (read & ~rd_in_range_s);
  end

  // Storage array and written flags.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      written_r <= '0;
    end else if (wr_en_s) begin
      mem_r[address_write]     <= data;
      written_r[address_write] <= 1'b1;
    end
  end

  // Stage-1 read-result register.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      s1_data_r  <= '0;
      s1_flags_r <= RD_FLAGS_IDLE;
    end else begin
      s1_data_r  <= s1_data_s;
      s1_flags_r <= s1_flags_s;
    end
  end

  // Saturating error counter; clear wins over an increment.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      err_cnt_r <= '0;
    end else if (err_clr) begin
      err_cnt_r <= '0;
    end else if ((s1_flags_s.err | s1_flags_s.err_oor) && (err_cnt_r != '1)) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_WIDTH'(1);
    end
  end

  if (READ_LATENCY == 2) begin : g_extra_stage
    mem_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (READ_LATENCY - 1)
    ) u_rd_pipe (
      .clk       (clk),
      .RESET_L   (RESET_L),
      .data_in   (s1_data_r),
      .flags_in  (s1_flags_r),
      .data_out  (pipe_data_s),
      .flags_out (pipe_flags_s)
    );
  end else begin : g_direct
    assign pipe_data_s  = s1_data_r;
    assign pipe_flags_s = s1_flags_r;
  end

  assign data_out  = pipe_data_s;
  assign valid_out = pipe_flags_s.valid;
  assign err       = pipe_flags_s.err;
  assign err_oor   = pipe_flags_s.err_oor;
  assign uninit    = pipe_flags_s.uninit;
  assign err_count = err_cnt_r;

endmodule

// File: tb/tb_mem_dp_pipe.sv
// Directed bench for mem_dp_pipe. Three configurations share one stimulus:
//   d0: defaults (collision error, depth 8, latency 1)
//   d1: write-first, depth 6, latency 1
//   d2: read-first, depth 8, latency 2
module tb_mem_dp_pipe;

  logic       clk;
  logic       RESET_L;
  logic       write;
  logic [2:0] address_write;
  logic [5:0] data;
  logic       read;
  logic [2:0] address_read;
  logic       err_clr;

  logic [5:0] d0_data_s, d1_data_s, d2_data_s;
  logic       d0_valid_s, d1_valid_s, d2_valid_s;
  logic       d0_err_s, d1_err_s, d2_err_s;
  logic       d0_oor_s, d1_oor_s, d2_oor_s;
  logic       d0_uninit_s, d1_uninit_s, d2_uninit_s;
  logic [3:0] d0_cnt_s, d1_cnt_s, d2_cnt_s;

  int total;
  int bad;

  mem_dp_pipe #(.COLLISION_MODE(0), .RAM_DEPTH(8), .READ_LATENCY(1)) u_d0 (
    .clk(clk), .RESET_L(RESET_L), .write(write), .address_write(address_write),
    .data(data), .read(read), .address_read(address_read), .err_clr(err_clr),
    .data_out(d0_data_s), .valid_out(d0_valid_s), .err(d0_err_s),
    .err_oor(d0_oor_s), .uninit(d0_uninit_s), .err_count(d0_cnt_s));

  mem_dp_pipe #(.COLLISION_MODE(1), .RAM_DEPTH(6), .READ_LATENCY(1)) u_d1 (
    .clk(clk), .RESET_L(RESET_L), .write(write), .address_write(address_write),
    .data(data), .read(read), .address_read(address_read), .err_clr(err_clr),
    .data_out(d1_data_s), .valid_out(d1_valid_s), .err(d1_err_s),
    .err_oor(d1_oor_s), .uninit(d1_uninit_s), .err_count(d1_cnt_s));

  mem_dp_pipe #(.COLLISION_MODE(2), .RAM_DEPTH(8), .READ_LATENCY(2)) u_d2 (
    .clk(clk), .RESET_L(RESET_L), .write(write), .address_write(address_write),
    .data(data), .read(read), .address_read(address_read), .err_clr(err_clr),
    .data_out(d2_data_s), .valid_out(d2_valid_s), .err(d2_err_s),
    .err_oor(d2_oor_s), .uninit(d2_uninit_s), .err_count(d2_cnt_s));

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of stimulus at the falling edge, then land 1 unit
  // after the next rising edge for sampling.
  task automatic step(input logic w, input logic [2:0] aw, input logic [5:0] d,
                      input logic r, input logic [2:0] ar, input logic clr);
    @(negedge clk);
    write = w; address_write = aw; data = d;
    read = r; address_read = ar; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 6'h00, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    RESET_L = 1'b0;
    write = 1'b0; address_write = 3'd0; data = 6'h00;
    read = 1'b0; address_read = 3'd0; err_clr = 1'b0;
    @(negedge clk);
    RESET_L = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (d0_data_s !== 6'h00) begin bad++; $display("FAIL reset_d0_data got=%h want=00", d0_data_s); end
    total++; if (d0_valid_s !== 1'b0) begin bad++; $display("FAIL reset_d0_valid got=%b want=0", d0_valid_s); end
    total++; if ({d0_err_s, d0_oor_s, d0_uninit_s} !== 3'b000) begin bad++; $display("FAIL reset_d0_flags got=%b want=000", {d0_err_s, d0_oor_s, d0_uninit_s}); end
    total++; if (d0_cnt_s !== 4'd0) begin bad++; $display("FAIL reset_d0_cnt got=%0d want=0", d0_cnt_s); end
    total++; if (d2_valid_s !== 1'b0) begin bad++; $display("FAIL reset_d2_valid got=%b want=0", d2_valid_s); end
  endtask

  task automatic test_basic();
    apply_reset();
    step(1'b1, 3'd3, 6'h2A, 1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 6'h00, 1'b1, 3'd3, 1'b0);
    total++; if (d0_data_s !== 6'h2A) begin bad++; $display("FAIL basic_d0_data got=%h want=2a", d0_data_s); end
    total++; if (d0_valid_s !== 1'b1) begin bad++; $display("FAIL basic_d0_valid got=%b want=1", d0_valid_s); end
    total++; if ({d0_err_s, d0_uninit_s} !== 2'b00) begin bad++; $display("FAIL basic_d0_err_uninit got=%b want=00", {d0_err_s, d0_uninit_s}); end
    total++; if (d1_data_s !== 6'h2A) begin bad++; $display("FAIL basic_d1_data got=%h want=2a", d1_data_s); end
    total++; if (d2_valid_s !== 1'b0) begin bad++; $display("FAIL basic_d2_early got=%b want=0", d2_valid_s); end
    idle();
    total++; if (d2_data_s !== 6'h2A || d2_valid_s !== 1'b1) begin bad++; $display("FAIL basic_d2_result got=%h/%b want=2a/1", d2_data_s, d2_valid_s); end
    total++; if (d0_valid_s !== 1'b0 || d0_data_s !== 6'h00) begin bad++; $display("FAIL basic_d0_idle got=%h/%b want=00/0", d0_data_s, d0_valid_s); end
  endtask

  task automatic test_collision_err();
    apply_reset();
    step(1'b1, 3'd5, 6'h07, 1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd5, 6'h15, 1'b1, 3'd5, 1'b0);
    total++; if (d0_valid_s !== 1'b0 || d0_data_s !== 6'h00) begin bad++; $display("FAIL coll0_drop got=%h/%b want=00/0", d0_data_s, d0_valid_s); end
    total++; if (d0_err_s !== 1'b1) begin bad++; $display("FAIL coll0_err got=%b want=1", d0_err_s); end
    total++; if (d0_cnt_s !== 4'd1) begin bad++; $display("FAIL coll0_cnt got=%0d want=1", d0_cnt_s); end
    total++; if (d1_data_s !== 6'h15 || d1_err_s !== 1'b0) begin bad++; $display("FAIL coll0_d1_wf got=%h/%b want=15/0", d1_data_s, d1_err_s); end
    idle();
    total++; if (d2_data_s !== 6'h07 || d2_err_s !== 1'b0) begin bad++; $display("FAIL coll0_d2_rf got=%h/%b want=07/0", d2_data_s, d2_err_s); end
    total++; if (d0_err_s !== 1'b0 || d0_cnt_s !== 4'd1) begin bad++; $display("FAIL coll0_after got=%b/%0d want=0/1", d0_err_s, d0_cnt_s); end
    step(1'b0, 3'd0, 6'h00, 1'b1, 3'd5, 1'b0);
    total++; if (d0_data_s !== 6'h07 || d0_valid_s !== 1'b1) begin bad++; $display("FAIL coll0_mem_kept got=%h/%b want=07/1", d0_data_s, d0_valid_s); end
  endtask

  task automatic test_collision_modes();
    apply_reset();
    step(1'b1, 3'd2, 6'h01, 1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd2, 6'h3F, 1'b1, 3'd2, 1'b0);
    total++; if (d1_data_s !== 6'h3F || d1_valid_s !== 1'b1) begin bad++; $display("FAIL wf_data got=%h/%b want=3f/1", d1_data_s, d1_valid_s); end
    total++; if ({d1_err_s, d1_uninit_s} !== 2'b00) begin bad++; $display("FAIL wf_flags got=%b want=00", {d1_err_s, d1_uninit_s}); end
    // Collision on a never-written entry.
    step(1'b1, 3'd4, 6'h3F, 1'b1, 3'd4, 1'b0);
    total++; if (d1_data_s !== 6'h3F || d1_uninit_s !== 1'b0) begin bad++; $display("FAIL wf_unwritten got=%h/%b want=3f/0", d1_data_s, d1_uninit_s); end
    total++; if (d2_data_s !== 6'h01 || d2_valid_s !== 1'b1 || d2_err_s !== 1'b0) begin bad++; $display("FAIL rf_data got=%h/%b/%b want=01/1/0", d2_data_s, d2_valid_s, d2_err_s); end
    total++; if (d2_uninit_s !== 1'b0) begin bad++; $display("FAIL rf_uninit got=%b want=0", d2_uninit_s); end
    step(1'b0, 3'd0, 6'h00, 1'b1, 3'd2, 1'b0);
    total++; if (d1_data_s !== 6'h3F) begin bad++; $display("FAIL wf_mem got=%h want=3f", d1_data_s); end
    total++; if (d2_data_s !== 6'h00 || d2_uninit_s !== 1'b1 || d2_valid_s !== 1'b1) begin bad++; $display("FAIL rf_unwritten got=%h/%b/%b want=00/1/1", d2_data_s, d2_uninit_s, d2_valid_s); end
    idle();
    total++; if (d2_data_s !== 6'h3F || d2_valid_s !== 1'b1) begin bad++; $display("FAIL rf_mem got=%h/%b want=3f/1", d2_data_s, d2_valid_s); end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 3'd1, 6'h11, 1'b1, 3'd7, 1'b0);
      if (i == 0) begin
        total++; if (d1_oor_s !== 1'b1 || d1_valid_s !== 1'b0 || d1_data_s !== 6'h00) begin bad++; $display("FAIL oor_first got=%b/%b/%h want=1/0/00", d1_oor_s, d1_valid_s, d1_data_s); end
        total++; if (d0_oor_s !== 1'b0 || d0_valid_s !== 1'b1 || d0_uninit_s !== 1'b1) begin bad++; $display("FAIL oor_d0_legal got=%b/%b/%b want=0/1/1", d0_oor_s, d0_valid_s, d0_uninit_s); end
      end
    end
    total++; if (d1_cnt_s !== 4'd15) begin bad++; $display("FAIL oor_saturate got=%0d want=15", d1_cnt_s); end
    total++; if (d0_cnt_s !== 4'd0) begin bad++; $display("FAIL oor_d0_cnt got=%0d want=0", d0_cnt_s); end
    step(1'b1, 3'd1, 6'h11, 1'b1, 3'd7, 1'b1);
    total++; if (d1_cnt_s !== 4'd0) begin bad++; $display("FAIL oor_clear_priority got=%0d want=0", d1_cnt_s); end
    step(1'b0, 3'd0, 6'h00, 1'b1, 3'd1, 1'b0);
    total++; if (d1_data_s !== 6'h11 || d1_valid_s !== 1'b1 || d1_oor_s !== 1'b0) begin bad++; $display("FAIL oor_write_kept got=%h/%b/%b want=11/1/0", d1_data_s, d1_valid_s, d1_oor_s); end
    total++; if (d1_cnt_s !== 4'd0) begin bad++; $display("FAIL oor_cnt_stays got=%0d want=0", d1_cnt_s); end
    step(1'b1, 3'd6, 6'h03, 1'b0, 3'd0, 1'b0);
    total++; if (d1_oor_s !== 1'b1 || d1_valid_s !== 1'b0 || d1_cnt_s !== 4'd1) begin bad++; $display("FAIL oor_write_only got=%b/%b/%0d want=1/0/1", d1_oor_s, d1_valid_s, d1_cnt_s); end
    total++; if (d0_oor_s !== 1'b0) begin bad++; $display("FAIL oor_d0_addr6 got=%b want=0", d0_oor_s); end
  endtask

  task automatic test_back_to_back();
    logic exp_valid [5];
    exp_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b0, 3'd0, 6'h00, 1'b1, 3'(i), 1'b0);
      else idle();
      total++; if (d2_valid_s !== exp_valid[i] || d2_uninit_s !== exp_valid[i] || d2_data_s !== 6'h00) begin
        bad++; $display("FAIL b2b_cycle%0d got=%b/%b/%h want=%b/%b/00", i, d2_valid_s, d2_uninit_s, d2_data_s, exp_valid[i], exp_valid[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    step(1'b1, 3'd3, 6'h2A, 1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 6'h00, 1'b1, 3'd3, 1'b0);
    #2;
    RESET_L = 1'b0;
    #1;
    total++; if (d0_valid_s !== 1'b0 || d0_data_s !== 6'h00) begin bad++; $display("FAIL rstmid_d0_now got=%h/%b want=00/0", d0_data_s, d0_valid_s); end
    total++; if (d2_valid_s !== 1'b0) begin bad++; $display("FAIL rstmid_d2_now got=%b want=0", d2_valid_s); end
    @(negedge clk);
    read = 1'b0;
    RESET_L = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idle();
      total++; if (d2_valid_s !== 1'b0 || d0_valid_s !== 1'b0) begin bad++; $display("FAIL rstmid_no_valid%0d got=%b/%b want=0/0", i, d2_valid_s, d0_valid_s); end
    end
    for (int a = 0; a < 8; a++) begin
      step(1'b0, 3'd0, 6'h00, 1'b1, 3'(a), 1'b0);
      total++; if (d0_data_s !== 6'h00 || d0_uninit_s !== 1'b1 || d0_valid_s !== 1'b1) begin
        bad++; $display("FAIL rstmid_entry%0d got=%h/%b/%b want=00/1/1", a, d0_data_s, d0_uninit_s, d0_valid_s);
      end
    end
  endtask

  // Run every scenario in order and report.
  initial begin
    total = 0;
    bad = 0;
    RESET_L = 1'b0;
    write = 1'b0; address_write = 3'd0; data = 6'h00;
    read = 1'b0; address_read = 3'd0; err_clr = 1'b0;
    test_reset();
    test_basic();
    test_collision_err();
    test_collision_modes();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
